switch_debouncer: RTL and testbench
===================================

// Module: switch_debouncer
// PURPOSE
//   Synchronises and debounces the 32-bit board switch word before it reaches the
//   switch-decode and seven-segment display path. Runs on the divided system clock (real_clk).
//   Publishes a stable word, a one-cycle write strobe and a per-bit change mask, so the
//   display drivers only refresh when the switches have really changed.
// PARAMETERS
//   WIDTH          32     switch word width
//   SYNC_STAGES    2      flip-flop synchroniser depth (>=2)
//   STABLE_CYCLES  20000  cycles the synchronised word must hold before commit (2 ms @10 MHz); >=1
//   CNT_W          15     settle counter width; must satisfy 2**CNT_W >= STABLE_CYCLES
// PORTS
//   clk      in   1      system clock (divided real_clk domain)
//   rst      in   1      synchronous, active-high reset
//   din      in   WIDTH  raw asynchronous switch levels
//   dout     out  WIDTH  debounced switch word (registered)
//   we       out  1      one-cycle pulse, high in the cycle dout takes a new value
//   changed  out  WIDTH  old_dout ^ new_dout; updated with we, held until next commit
//   stable   out  1      combinational: synchronised input == dout and state == IDLE
// BEHAVIOUR
//   Reset: sync chain, cand, cnt, dout, changed all 0; we 0; state IDLE (stable=1 once din=0).
//   Synchroniser: din passes through SYNC_STAGES flops; sync = last stage. No logic before stage 1.
//   FSM (2 states, all transitions on the rising edge of clk):
//     IDLE:     sync != dout -> cand<=sync, cnt<=0, go SETTLING. Otherwise stay; we<=0.
//     SETTLING: priority order:
//       1) sync == dout          -> go IDLE, cnt<=0, no commit (glitch rejected).
//       2) sync != cand          -> cand<=sync, cnt<=0, stay (bounce restarts window).
//       3) cnt == STABLE_CYCLES-1 -> dout<=cand, changed<=dout^cand, we<=1, go IDLE.
//       4) else                  -> cnt<=cnt+1.
//   we is registered; it is high for exactly one cycle per commit and is never high
//     for two consecutive cycles (after a commit, IDLE needs one edge to re-enter SETTLING).
//   Latency: edge 1 is the first edge that samples a new din held clean. dout/we update
//     on edge SYNC_STAGES+STABLE_CYCLES+1 (defaults: edge 20003).
//   Counter saturates by construction; it never wraps because it is cleared at value
//     STABLE_CYCLES-1. STABLE_CYCLES=1 commits on the edge after entering SETTLING.
//   Multi-bit changes: the whole word is debounced as one unit; any bit moving restarts
//     the window. Bits changing on different cycles produce a single commit of the final word.
//   Reset mid-SETTLING: the pending value is discarded, dout returns to 0 with no we pulse.
//     A held non-zero din then commits after the full latency from reset release.
//   rst has priority over every FSM action in the same cycle.
// STRUCTURE
//   Shared include debounce_defs.vh: state encodings (ST_IDLE=1'b0, ST_SETTLING=1'b1) and a
//     clog2 function for deriving CNT_W at instantiation.
//   Sub-module sync_ff #(WIDTH, SYNC_STAGES): plain N-stage synchroniser with synchronous reset.
//   Top: FSM, cand/cnt registers, output registers. we feeds the display write-enable,
//     and dout feeds the switch-decode input.
// TESTING  (bench uses STABLE_CYCLES=4, SYNC_STAGES=2, so latency = edge 7)
//   1 Reset for 3 cycles, din=0 -> dout=0, we=0, changed=0, stable=1 throughout.
//   2 din 0 -> 0x0000_00FF, held clean -> we high only on edge 7, dout=0xFF,
//     changed=0xFF, stable=1 from edge 8.
//   3 bit0 toggles every 2 cycles for 10 cycles, then held 1 -> exactly one we, 7 edges
//     after the last toggle sample, dout=0x1.
//   4 din 0 -> 0x8000_0000 for 3 cycles, then back to 0 -> no we, dout stays 0,
//     FSM returns to IDLE.
//   5 din 0x1 then 0x3 two cycles later, held -> one we only, dout=0x3, changed=0x3,
//     timed from the 0x3 sample.
//   6 rst pulsed while SETTLING on 0xABCD_0000 -> dout=0, no we. After release with din
//     held -> commit with dout=0xABCD_0000 on edge 7 after release.

Source files
------------

// File: rtl/switch_debouncer_pkg.sv
// Shared definitions for the switch debouncer: FSM state type and a width helper.
package switch_debouncer_pkg;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_SETTLING = 1'b1
  } state_e;

  // Bits needed to hold values 0..v-1; used to derive CNT_W from STABLE_CYCLES.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/switch_debouncer_sync_ff.sv
// Plain N-stage flip-flop synchroniser with synchronous active-high reset.
module sync_ff #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [SYNC_STAGES];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/switch_debouncer.sv
// Synchronises and debounces the switch word; publishes a stable word, a one-cycle
// write strobe and a per-bit change mask for the display path.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 20000,
  parameter int unsigned CNT_W         = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             we,
  output logic [WIDTH-1:0] changed,
  output logic             stable
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] w_sync;

  state_e           r_state,   w_state_nxt;
  logic [WIDTH-1:0] r_cand,    w_cand_nxt;
  logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;
  logic [WIDTH-1:0] r_dout,    w_dout_nxt;
  logic [WIDTH-1:0] r_changed, w_changed_nxt;
  logic             r_we,      w_we_nxt;

  sync_ff #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (din),
    .o_q   (w_sync)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cand    <= '0;
      r_cnt     <= '0;
      r_dout    <= '0;
      r_changed <= '0;
      r_we      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cand    <= w_cand_nxt;
      r_cnt     <= w_cnt_nxt;
      r_dout    <= w_dout_nxt;
      r_changed <= w_changed_nxt;
      r_we      <= w_we_nxt;
    end
  end

  // SETTLING priority: return-to-dout beats bounce restart beats commit.
  always_comb begin
    w_state_nxt   = r_state;
    w_cand_nxt    = r_cand;
    w_cnt_nxt     = r_cnt;
    w_dout_nxt    = r_dout;
    w_changed_nxt = r_changed;
    w_we_nxt      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_sync != r_dout) begin
          w_cand_nxt  = w_sync;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SETTLING;
        end
      end
      ST_SETTLING: begin
        if (w_sync == r_dout) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else if (w_sync != r_cand) begin
          w_cand_nxt = w_sync;
          w_cnt_nxt  = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_dout_nxt    = r_cand;
          w_changed_nxt = r_dout ^ r_cand;
          w_we_nxt      = 1'b1;
          w_cnt_nxt     = '0;
          w_state_nxt   = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign dout    = r_dout;
  assign we      = r_we;
  assign changed = r_changed;
  assign stable  = (w_sync == r_dout) && (r_state == ST_IDLE);

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with STABLE_CYCLES=4, SYNC_STAGES=2 (commit on edge 7).
module tb_switch_debouncer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        we;
  logic [31:0] changed;
  logic        stable;

  int tests  = 0;
  int failed = 0;
  int we_cnt;
  int we_edge;

  switch_debouncer #(
    .WIDTH         (32),
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (4),
    .CNT_W         (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .dout    (dout),
    .we      (we),
    .changed (changed),
    .stable  (stable)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs n edges with din held, recording the count and relative edge of we pulses.
  task automatic run_watch(input int n);
    we_cnt  = 0;
    we_edge = -1;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (we === 1'b1) begin
        we_cnt++;
        we_edge = k;
      end
    end
  endtask

  initial begin
    // 1: reset
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_dout", dout, 32'h0);
      check("rst_we", 32'(we), 32'h0);
      check("rst_changed", changed, 32'h0);
      check("rst_stable", 32'(stable), 32'h1);
    end
    rst = 1'b0;
    tick();
    check("idle_stable", 32'(stable), 32'h1);

    // 2: clean change to 0xFF
    din = 32'h0000_00FF;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check("c2_we", 32'(we), (k == 7) ? 32'h1 : 32'h0);
      if (k < 7) check("c2_dout_hold", dout, 32'h0);
      if (k >= 3 && k < 7) check("c2_unstable", 32'(stable), 32'h0);
    end
    check("c2_dout", dout, 32'h0000_00FF);
    check("c2_changed", changed, 32'h0000_00FF);
    tick();
    check("c2_we_off", 32'(we), 32'h0);
    check("c2_stable", 32'(stable), 32'h1);

    // 3: bit0 bouncing, then held at 1
    we_cnt = 0;
    for (int t = 0; t < 4; t++) begin
      din = (t % 2 == 0) ? 32'h1 : 32'h0;
      tick(); if (we === 1'b1) we_cnt++;
      tick(); if (we === 1'b1) we_cnt++;
    end
    check("c3_no_early_we", 32'(we_cnt), 32'h0);
    din = 32'h1;
    run_watch(10);
    check("c3_we_count", 32'(we_cnt), 32'h1);
    check("c3_we_edge", 32'(we_edge), 32'd7);
    check("c3_dout", dout, 32'h1);
    check("c3_changed", changed, 32'h0000_00FE);

    // return to 0 before the glitch test
    din = 32'h0;
    run_watch(10);
    check("pre4_dout", dout, 32'h0);

    // 4: short glitch on bit31 is rejected
    din = 32'h8000_0000;
    tick(); tick(); tick();
    check("c4_settling", 32'(stable), 32'h0);
    din = 32'h0;
    run_watch(10);
    check("c4_no_we", 32'(we_cnt), 32'h0);
    check("c4_dout", dout, 32'h0);
    check("c4_idle", 32'(stable), 32'h1);

    // 5: multi-bit change on different cycles gives one commit
    din = 32'h1;
    tick(); tick();
    din = 32'h3;
    run_watch(10);
    check("c5_we_count", 32'(we_cnt), 32'h1);
    check("c5_we_edge", 32'(we_edge), 32'd7);
    check("c5_dout", dout, 32'h3);
    check("c5_changed", changed, 32'h3);

    // 6: reset while SETTLING discards the pending value
    din = 32'hABCD_0000;
    tick(); tick(); tick(); tick();
    check("c6_settling", 32'(stable), 32'h0);
    check("c6_pre_dout", dout, 32'h3);
    rst = 1'b1;
    tick();
    check("c6_rst_dout", dout, 32'h0);
    check("c6_rst_we", 32'(we), 32'h0);
    check("c6_rst_changed", changed, 32'h0);
    rst = 1'b0;
    run_watch(10);
    check("c6_we_count", 32'(we_cnt), 32'h1);
    check("c6_we_edge", 32'(we_edge), 32'd7);
    check("c6_dout", dout, 32'hABCD_0000);
    check("c6_changed", changed, 32'hABCD_0000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
